// File: rtl/stopwatch_pkg.sv
// Shared state encoding and default parameters for the stopwatch control front-end.
package stopwatch_pkg;

  localparam int DEFAULT_DEBOUNCE  = 3;
  localparam int DEFAULT_LAP_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_t;

endpackage

// File: rtl/button_debounce.sv
// Single push-button debouncer: one o_press pulse per accepted press.
// A press is accepted after DEBOUNCE consecutive high samples. The debouncer
// then stays disarmed until DEBOUNCE consecutive low samples are seen.
module button_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int            CW   = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic          sample_q;
  logic          armed_q;
  logic [CW-1:0] cnt_q;

  // Register the raw button once, then count stable samples to press or re-arm.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sample_q <= 1'b0;
      armed_q  <= 1'b1;
      cnt_q    <= '0;
      o_press  <= 1'b0;
    end else begin
      sample_q <= i_btn;
      o_press  <= 1'b0;
      if (armed_q) begin
        if (!sample_q) begin
          cnt_q <= '0;
        end else if (cnt_q == LAST) begin
          o_press <= 1'b1;
          armed_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        if (sample_q) begin
          cnt_q <= '0;
        end else if (cnt_q == LAST) begin
          armed_q <= 1'b1;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button debouncing, mode FSM, counter run/clear and lap FIFO.
// Lap handshake: a head entry transfers on any edge where o_lap_valid and
// i_lap_ready are both high; o_lap_data is stable while o_lap_valid waits for ready.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE  = DEFAULT_DEBOUNCE,
  parameter int WIDTH     = 32,
  parameter int LAP_DEPTH = DEFAULT_LAP_DEPTH
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_btn_startstop,
  input  logic                           i_btn_lap,
  input  logic                           i_btn_clear,
  input  logic [WIDTH-1:0]               i_count,
  output logic                           o_run,
  output logic                           o_clear,
  output logic [1:0]                     o_state,
  output logic                           o_lap_valid,
  output logic [WIDTH-1:0]               o_lap_data,
  input  logic                           i_lap_ready,
  output logic [$clog2(LAP_DEPTH+1)-1:0] o_lap_count,
  output logic                           o_lap_overflow
);

  localparam int CNT_W = $clog2(LAP_DEPTH + 1);
  localparam int PW    = $clog2(LAP_DEPTH);

  logic ss_press, lap_press, clear_press;

  button_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_startstop (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_startstop), .o_press(ss_press)
  );
  button_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_lap (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_lap), .o_press(lap_press)
  );
  button_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_clear (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_clear), .o_press(clear_press)
  );

  state_t state_q, state_d;
  logic   clear_act;
  logic   lap_push;

  // Mode transitions; clear wins over start/stop, lap only counts while running.
  always_comb begin
    state_d   = state_q;
    clear_act = 1'b0;
    lap_push  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_press)   clear_act = 1'b1;
        else if (ss_press) state_d   = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (lap_press) lap_push = 1'b1;
        if (ss_press)  state_d  = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (clear_press) begin
          clear_act = 1'b1;
          state_d   = ST_IDLE;
        end else if (ss_press) begin
          state_d = ST_RUNNING;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus registered run-enable and clear pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      o_run   <= 1'b0;
      o_clear <= 1'b0;
    end else begin
      state_q <= state_d;
      o_run   <= (state_d == ST_RUNNING);
      o_clear <= clear_act;
    end
  end

  assign o_state = state_q;

  logic [WIDTH-1:0] mem_q [LAP_DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CNT_W-1:0] count_q;
  logic             full, pop, push, drop;

  assign full = (count_q == CNT_W'(LAP_DEPTH));
  assign pop  = (count_q != '0) && i_lap_ready;
  assign push = lap_push && (!full || pop);
  assign drop = lap_push && full && !pop;

  // Lap storage; a push while full is only allowed alongside a pop.
  always_ff @(posedge i_clk) begin
    if (push && !clear_act) mem_q[wr_q] <= i_count;
  end

  // FIFO pointers, occupancy and sticky overflow; flush overrides push/pop.
  always_ff @(posedge i_clk) begin
    if (i_reset || clear_act) begin
      wr_q           <= '0;
      rd_q           <= '0;
      count_q        <= '0;
      o_lap_overflow <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (drop) o_lap_overflow <= 1'b1;
    end
  end

  assign o_lap_valid = (count_q != '0);
  assign o_lap_data  = mem_q[rd_q];
  assign o_lap_count = count_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE=3, LAP_DEPTH=4.
module tb_stopwatch_ctrl;

  localparam int W = 32;

  // Clock / reset block
  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clk = ~i_clk;

  logic         btn_ss  = 1'b0;
  logic         btn_lap = 1'b0;
  logic         btn_clr = 1'b0;
  logic         lap_ready = 1'b0;
  logic [W-1:0] count_in = '0;

  logic         run, clear, lap_valid, lap_overflow;
  logic [1:0]   state;
  logic [W-1:0] lap_data;
  logic [2:0]   lap_count;

  stopwatch_ctrl #(.DEBOUNCE(3), .WIDTH(W), .LAP_DEPTH(4)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_btn_startstop(btn_ss),
    .i_btn_lap(btn_lap),
    .i_btn_clear(btn_clr),
    .i_count(count_in),
    .o_run(run),
    .o_clear(clear),
    .o_state(state),
    .o_lap_valid(lap_valid),
    .o_lap_data(lap_data),
    .i_lap_ready(lap_ready),
    .o_lap_count(lap_count),
    .o_lap_overflow(lap_overflow)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Hold buttons long enough for the press pulse and the FSM update (5 edges).
  task automatic press(input logic ss, input logic lp, input logic cl);
    btn_ss  = ss;
    btn_lap = lp;
    btn_clr = cl;
    tick(5);
  endtask

  // Release all buttons long enough for every debouncer to re-arm.
  task automatic release_all();
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    btn_clr = 1'b0;
    tick(5);
  endtask

  task automatic lap_at(input logic [W-1:0] v);
    count_in = v;
    press(1'b0, 1'b1, 1'b0);
    release_all();
  endtask

  logic [W-1:0] e;

  initial begin
    // Reset state
    tick(2);
    check("rst_run", run, 0);
    check("rst_state", state, 0);
    check("rst_clear", clear, 0);
    check("rst_valid", lap_valid, 0);
    check("rst_count", lap_count, 0);
    check("rst_ovf", lap_overflow, 0);
    i_reset = 1'b0;

    // Short glitches never reach the stable count
    btn_ss = 1'b1; tick(2);
    btn_ss = 1'b0; tick(1);
    btn_ss = 1'b1; tick(2);
    btn_ss = 1'b0; tick(5);
    check("glitch_run", run, 0);
    check("glitch_state", state, 0);

    // Button held through reset release: one press, o_run rises after edge 4
    i_reset = 1'b1;
    btn_ss  = 1'b1;
    tick(2);
    i_reset = 1'b0;
    tick(4);
    check("latency_run_e3", run, 0);
    tick(1);
    check("latency_run_e4", run, 1);
    check("latency_state", state, 1);
    tick(5);
    check("held_state", state, 1);
    check("held_run", run, 1);
    release_all();

    // Single lap capture and pop
    lap_at(100);
    check("lap1_valid", lap_valid, 1);
    check("lap1_data", lap_data, 100);
    check("lap1_count", lap_count, 1);
    lap_ready = 1'b1; tick(1); lap_ready = 1'b0;
    check("lap1_pop_count", lap_count, 0);
    check("lap1_pop_valid", lap_valid, 0);

    // Five laps into a four-entry FIFO
    for (int i = 0; i < 5; i++) begin
      lap_at(W'(11 + i));
      if (i < 4) exp_q.push_back(W'(11 + i));
    end
    check("ovf_count", lap_count, 4);
    check("ovf_flag", lap_overflow, 1);
    check("ovf_head", lap_data, 11);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      check("drain_data", lap_data, e);
      lap_ready = 1'b1; tick(1); lap_ready = 1'b0;
    end
    check("drain_count", lap_count, 2);
    check("drain_head", lap_data, exp_q[0]);

    // Pause, then clear and start/stop together
    press(1'b1, 1'b0, 1'b0);
    check("pause_state", state, 2);
    check("pause_run", run, 0);
    release_all();
    press(1'b1, 1'b0, 1'b1);
    check("clr_state", state, 0);
    check("clr_run", run, 0);
    check("clr_pulse", clear, 1);
    check("clr_count", lap_count, 0);
    check("clr_valid", lap_valid, 0);
    check("clr_ovf", lap_overflow, 0);
    tick(1);
    check("clr_pulse_end", clear, 0);
    exp_q.delete();
    release_all();

    // Lap ignored in IDLE
    lap_at(55);
    check("idle_lap_count", lap_count, 0);

    // Reset in the middle of a lap debounce
    press(1'b1, 1'b0, 1'b0);
    release_all();
    check("run2_state", state, 1);
    lap_at(200);
    lap_at(201);
    check("run2_count", lap_count, 2);
    btn_lap = 1'b1;
    tick(2);
    i_reset = 1'b1;
    btn_lap = 1'b0;
    tick(1);
    i_reset = 1'b0;
    check("mrst_state", state, 0);
    check("mrst_run", run, 0);
    check("mrst_count", lap_count, 0);
    check("mrst_clear", clear, 0);
    tick(6);
    check("mrst_count_later", lap_count, 0);
    check("mrst_state_later", state, 0);

    // Running: start/stop and lap together capture the lap and pause
    press(1'b1, 1'b0, 1'b0);
    release_all();
    count_in = 300;
    press(1'b1, 1'b1, 1'b0);
    check("sim_state", state, 2);
    check("sim_run", run, 0);
    check("sim_count", lap_count, 1);
    check("sim_data", lap_data, 300);
    release_all();

    // Clear from PAUSED alone
    press(1'b0, 1'b0, 1'b1);
    check("clr2_state", state, 0);
    check("clr2_pulse", clear, 1);
    check("clr2_count", lap_count, 0);
    release_all();

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
